max_pool_2x2: RTL
=================

Name: max_pool_2x2

Overview:
- Downstream stage of the convolution controller.
- Consumes the raster-ordered stream of convolution results (one averaged feature-map pixel per accepted beat, W x H per frame).
- Emits a 2x2, stride-2 max-pooled feature map of (W/2) x (H/2) pixels over a valid/ready interface.
- Buffers one half-row of horizontal pair maxima, so the full frame is never stored.

Parameters:
- DW, 9, pixel data width (matches convolution output width)
- W, 218, input feature-map width in pixels (220 - 3 + 1)
- H, 218, input feature-map height in pixels

Ports:
- clk  input  1  system clock; all state on rising edge
- rstn  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins a frame (honoured in IDLE only)
- in_valid  input  1  in_data holds a valid pixel
- in_ready  output  1  block accepts in_data this cycle
- in_data  input  DW  input pixel, unsigned, raster order
- out_valid  output  1  out_data holds a pooled pixel
- out_ready  input  1  downstream accepts out_data
- out_data  output  DW  pooled pixel, unsigned
- busy  output  1  high in RUN and DRAIN
- done  output  1  one-cycle pulse when the last pooled pixel is accepted

Behaviour:
- Reset (async, rstn=0): state=IDLE; in_ready=0, out_valid=0, out_data=0, busy=0, done=0; col/row counters=0. Line-buffer contents are don't-care.
- Reset asserted mid-frame aborts the frame immediately. No partial output is held afterwards.
- Beat transfer: a beat transfers when valid&&ready on a rising edge.
- in_ready is (state==RUN) && (!out_valid || out_ready). This is combinational, so a stalled output is overwritten only in the cycle it drains.
- FSM:
  - IDLE: start -> RUN; counters cleared.
  - RUN: accept pixels. After accepting pixel (W-1, H-1) -> DRAIN.
  - DRAIN: in_ready=0. When out_valid=0, or out_valid&&out_ready -> IDLE with done=1 for one cycle.
  - start outside IDLE is ignored.
- Counters:
  - col runs 0..W-1 and wraps to 0, incrementing row.
  - row runs 0..H-1.
  - Both advance only on accepted input beats.
- Pooling datapath:
  - Even col: hold pixel in a pair register.
  - Odd col: pm = max(pair_reg, in_data).
  - Even row: write pm to line buffer entry col>>1.
  - Odd row: result = max(pm, linebuf[col>>1]). Load result into out_data and set out_valid the cycle after the accepting edge (latency 1).
- Odd dimensions: a trailing odd column (col==W-1, W odd) and a trailing odd row (row==H-1, H odd) are consumed and discarded (floor semantics). Output is exactly (W/2)*(H/2) pixels.
- Output register: out_valid clears on out_valid&&out_ready unless a new result loads the same cycle, in which case it stays high with the new data.
- Comparison: unsigned DW-bit. Ties select either operand (equal values).

Optional Feature:
- Macro: POOL_AVG_EN.
- Defined:
  - Average pooling replaces max.
  - Pair register and line buffer hold DW+1-bit sums.
  - Result = (a+b+c+d) >> 2, truncated to DW bits (no rounding).
  - Latency and handshake are unchanged.
- Undefined: max pooling as above, and line-buffer width is DW.

Decomposition:
- Shared package pool_pkg contains:
  - the state enum (IDLE, RUN, DRAIN)
  - localparams OW=W/2, OH=H/2
  - counter widths $clog2(W) and $clog2(H)
  - line-buffer data width (DW, or DW+1 under POOL_AVG_EN)
- One sub-module, pool_line_buf: OW-entry register array with one synchronous write port and one asynchronous read port, indexed by col>>1.

Test Plan:
- W=4, H=4, DW=9, inputs 0..15 raster, out_ready=1 -> outputs 5, 7, 13, 15; done pulses once; total 4 outputs.
- W=218, H=218, random pixels 0..511, out_ready=1 -> 11881 outputs matching the reference max model; busy falls with done.
- W=5, H=5, inputs 0..24 -> outputs 6, 8, 16, 18; column 4 and row 4 are discarded.
- W=4, H=4, out_ready held 0 after the first output -> out_data stays 5; in_ready=0; no loss. Release -> remaining 7, 13, 15 in order.
- Mid-frame: rstn=0 after 6 beats -> all outputs 0 immediately. Restart with start -> a clean 4-output frame. start pulsed during RUN is ignored.
- POOL_AVG_EN, W=4, H=4, inputs 0..15 -> outputs 2, 4, 10, 12.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared types and sizing for the 2x2 stride-2 pooling stage.
// POOL_AVG_EN selects average pooling; max pooling otherwise.
package pool_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   localparam int DEF_DW = 9;
   localparam int DEF_W  = 218;
   localparam int DEF_H  = 218;

   localparam int OW = DEF_W / 2;
   localparam int OH = DEF_H / 2;

   localparam int CW = $clog2(DEF_W);
   localparam int RW = $clog2(DEF_H);

`ifdef POOL_AVG_EN
   localparam int LB_EXTRA = 1;
`else
   localparam int LB_EXTRA = 0;
`endif

   localparam int LBW = DEF_DW + LB_EXTRA;

   function automatic int cw_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-row buffer of horizontal pair results, indexed by col>>1.
// One synchronous write port, one asynchronous read port.
module pool_line_buf
   import pool_pkg::*;
#(
   parameter int N   = OW,
   parameter int DWL = LBW,
   parameter int AW  = cw_of(N)
) (
   input  logic           clk,
   input  logic           we,
   input  logic [AW-1:0]  waddr,
   input  logic [DWL-1:0] wdata,
   input  logic [AW-1:0]  raddr,
   output logic [DWL-1:0] rdata
);

   logic [DWL-1:0] mem [N];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/max_pool_2x2.sv
// 2x2 stride-2 pooling of a raster pixel stream over valid/ready.
// Define POOL_AVG_EN for average pooling instead of max.
module max_pool_2x2
   import pool_pkg::*;
#(
   parameter int DW = DEF_DW,
   parameter int W  = DEF_W,
   parameter int H  = DEF_H
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          start,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          busy,
   output logic          done
);

   localparam int OWL = (W / 2 > 0) ? W / 2 : 1;
   localparam int CWL = cw_of(W);
   localparam int RWL = cw_of(H);
   localparam int AWL = cw_of(OWL);
   localparam int LW  = DW + LB_EXTRA;

   state_t          state;
   logic [CWL-1:0]  col;
   logic [RWL-1:0]  row;
   logic [LW-1:0]   pair_q;
   logic [LW-1:0]   pm;
   logic [LW-1:0]   lb_rd;
   logic [DW-1:0]   res;
   logic [AWL-1:0]  addr;
   logic            acc;
   logic            col_last;
   logic            row_last;
   logic            lb_we;
   logic            load;

   assign in_ready = (state == RUN) && (!out_valid || out_ready);
   assign acc      = in_valid && in_ready;
   assign col_last = (col == CWL'(W - 1));
   assign row_last = (row == RWL'(H - 1));
   assign addr     = AWL'(col >> 1);
   assign lb_we    = acc && col[0] && !row[0];
   assign load     = acc && col[0] && row[0];

`ifdef POOL_AVG_EN
   logic [LW:0] sum4;

   assign pm   = pair_q + LW'(in_data);
   assign sum4 = {1'b0, pm} + {1'b0, lb_rd};
   assign res  = sum4[DW+1:2];
`else
   assign pm  = (in_data > pair_q) ? in_data : pair_q;
   assign res = (pm > lb_rd) ? pm : lb_rd;
`endif

   pool_line_buf #(
      .N   (OWL),
      .DWL (LW),
      .AW  (AWL)
   ) u_lb (
      .clk   (clk),
      .we    (lb_we),
      .waddr (addr),
      .wdata (pm),
      .raddr (addr),
      .rdata (lb_rd)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         col       <= '0;
         row       <= '0;
         pair_q    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;

         if (acc && !col[0]) pair_q <= LW'(in_data);

         // A fresh result keeps out_valid high even while draining
         if (load) begin
            out_valid <= 1'b1;
            out_data  <= res;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         unique case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
                  busy  <= 1'b1;
                  col   <= '0;
                  row   <= '0;
               end
            end
            RUN: begin
               if (acc) begin
                  if (col_last) begin
                     col <= '0;
                     row <= row_last ? '0 : row + 1'b1;
                  end else begin
                     col <= col + 1'b1;
                  end
                  if (col_last && row_last) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (!out_valid || out_ready) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
